// File: rtl/m_mem_access_pkg.sv
// Shared constants and store-lane helpers for the M-stage memory access controller.
package m_mem_access_pkg;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_B  = 3'd2;
  localparam logic [2:0] DM_HU = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TC1_LO = 32'h0000_7F10;
  localparam logic [31:0] TC1_HI = 32'h0000_7F1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] lane_strb(input logic [2:0] dmop, input logic [1:0] lo);
    case (dmop)
      DM_H, DM_HU: lane_strb = 4'b0011 << lo;
      DM_B, DM_BU: lane_strb = 4'b0001 << lo;
      default:     lane_strb = 4'b1111;
    endcase
  endfunction

  // Replicate narrow data across the word so every lane the strobe selects is correct.
  function automatic logic [31:0] lane_data(input logic [2:0] dmop, input logic [31:0] wdata);
    case (dmop)
      DM_H, DM_HU: lane_data = {2{wdata[15:0]}};
      DM_B, DM_BU: lane_data = {4{wdata[7:0]}};
      default:     lane_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/m_addr_check.sv
// Combinational legality check of an M-stage access: alignment, address map, timer rules.
module m_addr_check
  import m_mem_access_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [2:0]  dmop,
  output logic        legal,
  output logic [4:0]  code
);

  logic aligned;
  logic is_word;
  logic in_dm;
  logic in_tc;
  logic tc_bad;

  always_comb begin
    aligned = 1'b0;
    is_word = 1'b0;
    case (dmop)
      DM_W: begin
        aligned = (addr[1:0] == 2'b00);
        is_word = 1'b1;
      end
      DM_H, DM_HU: aligned = !addr[0];
      DM_B, DM_BU: aligned = 1'b1;
      default:     aligned = 1'b0;
    endcase
  end

  assign in_dm  = (addr <= DM_HI);
  assign in_tc  = ((addr >= TC0_LO) && (addr <= TC0_HI)) ||
                  ((addr >= TC1_LO) && (addr <= TC1_HI));
  // Timers take word accesses only, and their COUNT register is read-only.
  assign tc_bad = in_tc && (!is_word || (we && (addr[3:0] == 4'h8)));
  assign legal  = aligned && (in_dm || in_tc) && !tc_bad;
  assign code   = we ? EXC_ADES : EXC_ADEL;

endmodule

// File: rtl/m_mem_access.sv
// M-stage load/store controller: legality check, byte lanes, req/gnt/rvalid handshake,
// pipeline stall and bus timeout.
//  state  | meaning
//  IDLE   | no transfer; accept a legal, unflushed request
//  REQ    | bus_req high, waiting for gnt
//  WAIT   | load granted, waiting for rvalid
//  DONE   | one-cycle completion pulse, rd_* updated
module m_mem_access
  import m_mem_access_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmop,
  input  logic        flush,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rd_word,
  output logic [1:0]  rd_lo,
  output logic [2:0]  rd_dmop,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  localparam int              CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_TC = CW'(TIMEOUT - 1);

  state_e          state_q, state_nxt;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [1:0]      lo_q;
  logic [2:0]      dmop_q;
  logic            legal;
  logic [4:0]      chk_code;
  logic            accept;
  logic            reject;
  logic            tmo;

  m_addr_check u_addr_check (
    .addr  (req_addr),
    .we    (req_we),
    .dmop  (req_dmop),
    .legal (legal),
    .code  (chk_code)
  );

  assign accept = (state_q == S_IDLE) && req_valid && !flush && legal;
  assign reject = (state_q == S_IDLE) && req_valid && !flush && !legal;
  assign tmo    = (((state_q == S_REQ) && !bus_gnt) || ((state_q == S_WAIT) && !bus_rvalid))
                  && (cnt_q == CNT_TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ: begin
        if (bus_gnt)  state_nxt = we_q ? S_DONE : S_WAIT;
        else if (tmo) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (bus_rvalid) state_nxt = S_DONE;
        else if (tmo)   state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: stall = accept;
      S_REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
      end
      S_WAIT:  stall = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      we_q      <= 1'b0;
      lo_q      <= '0;
      dmop_q    <= '0;
      rd_word   <= '0;
      rd_lo     <= '0;
      rd_dmop   <= '0;
      exc_valid <= 1'b0;
      exc_code  <= '0;
      cnt_q     <= '0;
    end else begin
      exc_valid <= 1'b0;
      exc_code  <= '0;
      if (accept) begin
        bus_addr  <= {req_addr[31:2], 2'b00};
        bus_wstrb <= req_we ? lane_strb(req_dmop, req_addr[1:0]) : 4'b0000;
        bus_wdata <= req_we ? lane_data(req_dmop, req_wdata) : 32'h0;
        we_q      <= req_we;
        lo_q      <= req_addr[1:0];
        dmop_q    <= req_dmop;
      end
      if (reject) begin
        exc_valid <= 1'b1;
        exc_code  <= chk_code;
      end
      if (tmo) begin
        exc_valid <= 1'b1;
        exc_code  <= EXC_DBE;
      end
      if ((state_q == S_WAIT) && bus_rvalid) rd_word <= bus_rdata;
      if (state_nxt == S_DONE) begin
        rd_lo   <= lo_q;
        rd_dmop <= dmop_q;
      end
      if (((state_nxt == S_REQ) || (state_nxt == S_WAIT)) && (state_nxt != state_q))
        cnt_q <= '0;
      else if ((state_q == S_REQ) || (state_q == S_WAIT))
        cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_m_mem_access.sv
// Directed bench for m_mem_access with hand-computed expectations.
module tb_m_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_dmop = '0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall;
  logic        done;
  logic [31:0] rd_word;
  logic [1:0]  rd_lo;
  logic [2:0]  rd_dmop;
  logic        exc_valid;
  logic [4:0]  exc_code;

  int n_chk  = 0;
  int n_pass = 0;

  m_mem_access #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dmop   (req_dmop),
    .flush      (flush),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .done       (done),
    .rd_word    (rd_word),
    .rd_lo      (rd_lo),
    .rd_dmop    (rd_dmop),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && bus_req && bus_gnt && bus_rvalid)
      $error("bridge contract broken: gnt and rvalid together in REQ");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] dmop);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_dmop  = dmop;
  endtask

  task automatic illegal(input string tag, input logic we, input logic [31:0] addr,
                         input logic [2:0] dmop, input logic [4:0] code);
    step; issue(we, addr, 32'hFFFF_FFFF, dmop);
    smp;  check({tag, " stall"}, stall, 0);
          check({tag, " req"}, bus_req, 0);
    step; req_valid = 1'b0;
    smp;  check({tag, " exc_valid"}, exc_valid, 1);
          check({tag, " exc_code"}, exc_code, code);
          check({tag, " req after"}, bus_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    smp;
    check("rst outs", {bus_req, stall, done, exc_valid, bus_wstrb}, 0);
    check("rst rd_word", rd_word, 0);
    check("rst bus_addr", bus_addr, 0);
    reset = 1'b1;

    // 1: lw 0x10, gnt in cycle 1, rvalid in cycle 3
    step; issue(0, 32'h10, 0, 3'd0);
    smp;  check("t1 stall acc", stall, 1);
    step; req_valid = 1'b0; bus_gnt = 1'b1;
    smp;  check("t1 bus_req", bus_req, 1);
          check("t1 bus_addr", bus_addr, 32'h10);
          check("t1 wstrb", bus_wstrb, 0);
    step; bus_gnt = 1'b0;
    smp;  check("t1 stall wait", stall, 1);
    step; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    smp;  check("t1 no done yet", done, 0);
    step; bus_rvalid = 1'b0;
    smp;  check("t1 done", done, 1);
          check("t1 rd_word", rd_word, 32'hDEAD_BEEF);
          check("t1 rd_lo", rd_lo, 0);
          check("t1 stall done", stall, 0);
    step;
    smp;  check("t1 done pulse", done, 0);

    // 2: sb 0x13, gnt in first REQ cycle
    step; issue(1, 32'h13, 32'h1234_5678, 3'd2);
    step; req_valid = 1'b0; bus_gnt = 1'b1;
    smp;  check("t2 wstrb", bus_wstrb, 4'b1000);
          check("t2 wdata", bus_wdata, 32'h7878_7878);
          check("t2 addr", bus_addr, 32'h10);
    step; bus_gnt = 1'b0;
    smp;  check("t2 done", done, 1);
          check("t2 rd_lo", rd_lo, 3);
          check("t2 rd_dmop", rd_dmop, 2);
          check("t2 rd_word held", rd_word, 32'hDEAD_BEEF);

    // sh 0x2FFE at the top of data memory, gnt after two REQ cycles
    step; issue(1, 32'h2FFE, 32'hAABB_CCDD, 3'd1);
    step; req_valid = 1'b0;
    smp;  check("sh wstrb", bus_wstrb, 4'b1100);
          check("sh wdata", bus_wdata, 32'hCCDD_CCDD);
          check("sh addr", bus_addr, 32'h2FFC);
    step;
    smp;  check("sh still req", bus_req, 1);
    step; bus_gnt = 1'b1;
    step; bus_gnt = 1'b0;
    smp;  check("sh done", done, 1);
          check("sh rd_lo", rd_lo, 2);

    // 3: illegal accesses
    illegal("lh 0x1", 0, 32'h1, 3'd1, 5'd4);
    illegal("sw 0x7F08", 1, 32'h7F08, 3'd0, 5'd5);
    illegal("sb 0x7F00", 1, 32'h7F00, 3'd2, 5'd5);
    illegal("lw 0x3000", 0, 32'h3000, 3'd0, 5'd4);
    illegal("lw 0x7F0C", 0, 32'h7F0C, 3'd0, 5'd4);
    illegal("sw 0x2", 1, 32'h2, 3'd0, 5'd5);

    // 4: lw with gnt withheld -> bus timeout after TIMEOUT REQ cycles
    step; issue(0, 32'h20, 0, 3'd0);
    step; req_valid = 1'b0;
    smp;
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      step; smp;
    end
    check("t4 req cycles", n, 64);
    check("t4 exc_valid", exc_valid, 1);
    check("t4 exc_code", exc_code, 5'd7);
    check("t4 done", done, 0);
    check("t4 stall", stall, 0);

    // 5: flush in IDLE blocks acceptance, also for an illegal address
    step; issue(0, 32'h10, 0, 3'd0); flush = 1'b1;
    smp;  check("t5 flush stall", stall, 0);
    step; req_valid = 1'b0; flush = 1'b0;
    smp;  check("t5 flush req", bus_req, 0);
    step; issue(0, 32'h1, 0, 3'd1); flush = 1'b1;
    step; req_valid = 1'b0; flush = 1'b0;
    smp;  check("t5 flush no exc", exc_valid, 0);

    // flush in WAIT is ignored (lw TC1 COUNT)
    step; issue(0, 32'h7F18, 0, 3'd0);
    step; req_valid = 1'b0; bus_gnt = 1'b1;
    step; bus_gnt = 1'b0; flush = 1'b1;
    smp;  check("t5 wait stall", stall, 1);
    step; bus_rvalid = 1'b1; bus_rdata = 32'h42;
    step; bus_rvalid = 1'b0;
    smp;  check("t5 done", done, 1);
          check("t5 rd_word", rd_word, 32'h42);
    flush = 1'b0;

    // 6: reset during WAIT, then a normal load
    step; issue(0, 32'h40, 0, 3'd0);
    step; req_valid = 1'b0; bus_gnt = 1'b1;
    step; bus_gnt = 1'b0;
    smp;  check("t6 in wait", stall, 1);
    #1 reset = 1'b0;
    #1 check("t6 rst outs", {bus_req, stall, done, exc_valid, bus_wstrb}, 0);
       check("t6 rst rd_word", rd_word, 0);
       check("t6 rst addr", bus_addr, 0);
    step; smp; reset = 1'b1;
    step; issue(0, 32'h44, 0, 3'd0);
    step; req_valid = 1'b0; bus_gnt = 1'b1;
    smp;  check("t6 addr", bus_addr, 32'h44);
    step; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step; bus_rvalid = 1'b0;
    smp;  check("t6 done", done, 1);
          check("t6 rd_word", rd_word, 32'hCAFE_F00D);
          check("t6 rd_lo", rd_lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
